down_cnt_timer: RTL and testbench



---
 rtl/down_cnt_pkg.sv | 11 +
 rtl/down_cnt_core.sv | 31 +++
 rtl/down_cnt_timer.sv | 134 +++++++++++++
 tb/tb_down_cnt_timer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/down_cnt_pkg.sv
// Shared types and constants for the down-counting timer.
package down_cnt_pkg;
   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;
endpackage

// File: rtl/down_cnt_core.sv
// WIDTH-bit count register with load, decrement and hold; flags count==1 and count==0.
import down_cnt_pkg::*;

module down_cnt_core #(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             dec,
   output logic [WIDTH-1:0] count,
   output logic             is_one,
   output logic             is_zero
);
   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (dec) begin
         count_reg <= count_reg - WIDTH'(1);
      end
   end

   assign count   = count_reg;
   assign is_one  = (count_reg == WIDTH'(1));
   assign is_zero = (count_reg == '0);
endmodule

// File: rtl/down_cnt_timer.sv
// Loadable down-counting timer: FSM, reload register and registered tc/done/busy flags
// wrapped around the count register.
import down_cnt_pkg::*;

module down_cnt_timer #(
   parameter int WIDTH = CNT_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             start,
   input  logic             pause,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] counter,
   output logic             busy,
   output logic             tc,
   output logic             done
);
   state_t           state_reg, state_next;
   logic [WIDTH-1:0] reload_reg, reload_next;
   logic             tc_reg, tc_next;
   logic             done_reg, done_next;
   logic             busy_reg, busy_next;

   logic             cnt_load, cnt_dec, cnt_one, cnt_zero;
   logic [WIDTH-1:0] cnt_val, cnt_q;

   down_cnt_core #(.WIDTH(WIDTH)) u_core (
      .clk      (clk),
      .reset    (reset),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .count    (cnt_q),
      .is_one   (cnt_one),
      .is_zero  (cnt_zero)
   );

   always_comb begin
      state_next  = state_reg;
      reload_next = reload_reg;
      tc_next     = 1'b0;
      done_next   = done_reg;
      cnt_load    = 1'b0;
      cnt_val     = load_val;
      cnt_dec     = 1'b0;

      if (load) begin
         cnt_load    = 1'b1;
         reload_next = load_val;
         state_next  = IDLE;
         done_next   = 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (cnt_zero) begin
                     state_next = DONE;
                     tc_next    = 1'b1;
                     done_next  = 1'b1;
                  end else begin
                     state_next = RUN;
                  end
               end
            end
            // Leaving PAUSE counts on the same edge, so a countdown is
            // stretched by exactly the number of edges that saw pause high.
            RUN, PAUSE: begin
               if (pause) begin
                  state_next = PAUSE;
               end else begin
                  state_next = RUN;
                  if (cnt_one) begin
                     cnt_dec = 1'b1;
                     tc_next = 1'b1;
                     if (!auto_reload) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                     end
                  end else if (cnt_zero) begin
                     if (auto_reload) begin
                        cnt_load = 1'b1;
                        cnt_val  = reload_reg;
                        tc_next  = (reload_reg == '0);
                     end else begin
                        state_next = DONE;
                        done_next  = 1'b1;
                     end
                  end else begin
                     cnt_dec = 1'b1;
                  end
               end
            end
            DONE: begin
               if (start) begin
                  if (reload_reg != '0) begin
                     cnt_load   = 1'b1;
                     cnt_val    = reload_reg;
                     state_next = RUN;
                     done_next  = 1'b0;
                  end else begin
                     tc_next = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end

      busy_next = (state_next == RUN) || (state_next == PAUSE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         reload_reg <= '0;
         tc_reg     <= 1'b0;
         done_reg   <= 1'b0;
         busy_reg   <= 1'b0;
      end else begin
         state_reg  <= state_next;
         reload_reg <= reload_next;
         tc_reg     <= tc_next;
         done_reg   <= done_next;
         busy_reg   <= busy_next;
      end
   end

   assign counter = cnt_q;
   assign busy    = busy_reg;
   assign tc      = tc_reg;
   assign done    = done_reg;
endmodule

// File: tb/tb_down_cnt_timer.sv
// Scoreboard bench: stimulus pushes reference-model expectations, a monitor pops and compares.
module tb_down_cnt_timer;
   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       load = 1'b0;
   logic [3:0] load_val = '0;
   logic       start = 1'b0;
   logic       pause = 1'b0;
   logic       auto_reload = 1'b0;
   logic [3:0] counter;
   logic       busy, tc, done;

   int checks = 0;
   int failures = 0;
   int txn = 0;

   typedef struct {
      logic [3:0] cnt;
      logic       busy;
      logic       tc;
      logic       done;
   } exp_t;

   exp_t sb[$];

   // reference model
   int m_cnt, m_rel;
   bit m_run, m_paused, m_exp, m_tc;

   down_cnt_timer #(.WIDTH(4)) dut (
      .clk         (clk),
      .reset       (reset),
      .load        (load),
      .load_val    (load_val),
      .start       (start),
      .pause       (pause),
      .auto_reload (auto_reload),
      .counter     (counter),
      .busy        (busy),
      .tc          (tc),
      .done        (done)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "timeout");
   end

   task automatic model_reset();
      m_cnt = 0; m_rel = 0; m_run = 0; m_paused = 0; m_exp = 0; m_tc = 0;
   endtask

   task automatic model_step(input bit l, input int lv, input bit s, input bit p, input bit a);
      m_tc = 0;
      if (l) begin
         m_cnt = lv; m_rel = lv; m_run = 0; m_paused = 0; m_exp = 0;
      end else if (m_run && p) begin
         m_paused = 1;
      end else if (m_run) begin
         m_paused = 0;
         if (m_cnt > 1) begin
            m_cnt = m_cnt - 1;
         end else if (m_cnt == 1) begin
            m_cnt = 0;
            m_tc  = 1;
            if (!a) begin m_run = 0; m_exp = 1; end
         end else if (a) begin
            m_cnt = m_rel;
            m_tc  = (m_rel == 0);
         end else begin
            m_run = 0; m_exp = 1;
         end
      end else if (m_exp && s) begin
         if (m_rel != 0) begin
            m_cnt = m_rel; m_run = 1; m_exp = 0;
         end else begin
            m_tc = 1;
         end
      end else if (!m_exp && s) begin
         if (m_cnt != 0) m_run = 1;
         else begin m_exp = 1; m_tc = 1; end
      end
   endtask

   task automatic cyc(input bit l, input int lv, input bit s, input bit p, input bit a);
      exp_t e;
      @(negedge clk);
      load = l; load_val = 4'(lv); start = s; pause = p; auto_reload = a;
      model_step(l, lv, s, p, a);
      e.cnt = 4'(m_cnt); e.busy = m_run; e.tc = m_tc; e.done = m_exp;
      sb.push_back(e);
      @(posedge clk);
   endtask

   task automatic check_now(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", name, got, want);
      end else begin
         $display("check %s value=%0d", name, got);
      end
   endtask

   // monitor: one comparison per clock while expectations are pending
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            txn++;
            checks++;
            if (counter !== e.cnt || busy !== e.busy || tc !== e.tc || done !== e.done) begin
               failures++;
               $display("FAIL txn%0d got cnt=%0d busy=%0b tc=%0b done=%0b expected cnt=%0d busy=%0b tc=%0b done=%0b",
                        txn, counter, busy, tc, done, e.cnt, e.busy, e.tc, e.done);
            end else begin
               $display("txn%0d cnt=%0d busy=%0b tc=%0b done=%0b", txn, counter, busy, tc, done);
            end
         end
      end
   end

   initial begin
      model_reset();
      #22;
      check_now("reset_counter", int'(counter), 0);
      check_now("reset_busy", int'(busy), 0);
      check_now("reset_tc", int'(tc), 0);
      check_now("reset_done", int'(done), 0);
      @(negedge clk);
      reset = 1'b1;

      // one-shot countdown of 5
      cyc(1, 5, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (8) cyc(0, 0, 0, 0, 0);

      // periodic mode, reload 3
      cyc(1, 3, 0, 0, 1);
      cyc(0, 0, 1, 0, 1);
      repeat (10) cyc(0, 0, 0, 0, 1);

      // pause for three edges after the first decrement
      cyc(1, 4, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);
      repeat (3) cyc(0, 0, 0, 1, 0);
      repeat (5) cyc(0, 0, 0, 0, 0);

      // zero load: immediate expiry, restart from DONE with zero reload
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 0, 0, 0);

      // load beats pause and start during RUN at count 6
      cyc(1, 8, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (2) cyc(0, 0, 0, 0, 0);
      cyc(1, 9, 1, 1, 0);
      cyc(0, 0, 0, 0, 0);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         bit l, s, p, a;
         l = ($urandom_range(0, 11) == 0);
         s = ($urandom_range(0, 3) == 0);
         p = ($urandom_range(0, 5) == 0);
         a = ($urandom_range(0, 7) < 3);
         cyc(l, int'($urandom_range(0, 7)), s, p, a);
      end

      // asynchronous reset mid-RUN at count 7
      cyc(1, 7, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      #3;
      reset = 1'b0;
      model_reset();
      #1;
      check_now("async_rst_counter", int'(counter), 0);
      check_now("async_rst_busy", int'(busy), 0);
      check_now("async_rst_tc", int'(tc), 0);
      check_now("async_rst_done", int'(done), 0);
      load = 1'b0; start = 1'b0; pause = 1'b0; auto_reload = 1'b0;
      @(posedge clk);
      #2;
      check_now("held_rst_counter", int'(counter), 0);
      @(negedge clk);
      reset = 1'b1;

      // after reset: reload register is cleared, so start expires at once
      cyc(0, 0, 1, 0, 0);
      cyc(1, 2, 0, 0, 0);
      cyc(0, 0, 1, 0, 0);
      repeat (4) cyc(0, 0, 0, 0, 0);

      #5;
      check_now("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
